// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with sign and overflow saturation.
// Optional leading-zero blank mask output when BCD_BLANK_EN is defined.
module bin2bcd_seq #(
    parameter int WIDTH  = 20,
    parameter int DIGITS = 6
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [WIDTH-1:0]    data_bny,
    input  logic                neg,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                neg_out,
    output logic                ovf
`ifdef BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]   blank
`endif
);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] MAXVAL = pow10(DIGITS) - 64'd1;
    localparam int SW  = 4*DIGITS + 4;
    localparam int ITW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state, state_nxt;
    logic                accept;
    logic [WIDTH-1:0]    bin;
    logic [SW-1:0]       scratch;
    logic [SW-1:0]       adj;
    logic [SW-1:0]       scratch_sh;
    logic [WIDTH-1:0]    bin_sh;
    logic                unused_carry;
    logic                sign;
    logic                ovf_i;
    logic [ITW-1:0]      iter;
    logic [4*DIGITS-1:0] result;
`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0]   blank_nxt;
    logic                all_zero;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT:   if (iter == ITW'(WIDTH - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // All digits are corrected in parallel before the one-bit shift.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS + 1; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    // The guard digit is never >= 8 after correction, so its top bit is always zero.
    assign {unused_carry, scratch_sh, bin_sh} = {adj, bin, 1'b0};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bin     <= '0;
            scratch <= '0;
            sign    <= 1'b0;
            ovf_i   <= 1'b0;
            iter    <= '0;
        end else if (accept) begin
            bin     <= data_bny;
            scratch <= '0;
            sign    <= neg;
            ovf_i   <= (64'(data_bny) > MAXVAL);
            iter    <= '0;
        end else if (state == SHIFT) begin
            bin     <= bin_sh;
            scratch <= scratch_sh;
            iter    <= iter + 1'b1;
        end
    end

    assign result = ovf_i ? {DIGITS{4'h9}} : scratch[4*DIGITS-1:0];

`ifdef BCD_BLANK_EN
    // A digit is blanked only when it and every higher digit are zero; units always shown.
    always_comb begin
        blank_nxt = '0;
        all_zero  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero     = all_zero & (result[4*i +: 4] == 4'd0);
            blank_nxt[i] = all_zero;
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done    <= 1'b0;
            bcd     <= '0;
            neg_out <= 1'b0;
            ovf     <= 1'b0;
`ifdef BCD_BLANK_EN
            blank   <= '0;
`endif
        end else begin
            done <= (state == DONE);
            if (state == DONE) begin
                bcd     <= result;
                neg_out <= sign & (|result);
                ovf     <= ovf_i;
`ifdef BCD_BLANK_EN
                blank   <= blank_nxt;
`endif
            end
        end
    end

    assign busy = (state != IDLE) | done;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed and random conversions against an
// arithmetic reference model (digits by repeated division, saturation at 999999).
module tb_bin2bcd_seq;

    localparam int WIDTH  = 20;
    localparam int DIGITS = 6;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [19:0] data_bny;
    logic        neg;
    logic        busy;
    logic        done;
    logic [23:0] bcd;
    logic        neg_out;
    logic        ovf;
`ifdef BCD_BLANK_EN
    logic [5:0]  blank;
`endif

    int checks = 0;
    int errors = 0;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk(clk), .rstn(rstn), .start(start), .data_bny(data_bny), .neg(neg),
        .busy(busy), .done(done), .bcd(bcd), .neg_out(neg_out), .ovf(ovf)
`ifdef BCD_BLANK_EN
        , .blank(blank)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] model_bcd(input int unsigned v);
        logic [23:0] r;
        int unsigned x;
        if (v > 999999) return 24'h999999;
        r = '0;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [5:0] model_blank(input int unsigned v);
        logic [5:0] m;
        int unsigned lim;
        m = '0;
        lim = 10;
        // Digit i is blank when the value is below 10^i (digit 0 never blank).
        for (int i = 1; i < 6; i++) begin
            if (v < lim && v <= 999999) m[i] = 1'b1;
            lim = lim * 10;
        end
        return m;
    endfunction

    task automatic check_result(input string tag, input int unsigned v, input logic n);
        check({tag, "_bcd"}, 32'(bcd), 32'(model_bcd(v)));
        check({tag, "_neg"}, 32'(neg_out), 32'(n && v != 0));
        check({tag, "_ovf"}, 32'(ovf), 32'(v > 999999));
`ifdef BCD_BLANK_EN
        check({tag, "_blank"}, 32'(blank), 32'(model_blank(v)));
`endif
    endtask

    // One conversion from an idle FSM; returns edges from accept to done pulse.
    task automatic do_conv(input logic [19:0] v, input logic n, output int lat,
                           output logic busy_ok, output logic stable_ok);
        logic [23:0] prev;
        lat = -1;
        busy_ok = 1'b1;
        stable_ok = 1'b1;
        @(negedge clk);
        data_bny = v;
        neg = n;
        start = 1'b1;
        prev = bcd;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        data_bny = 20'($urandom);
        neg = 1'($urandom);
        for (int e = 1; e <= 60; e++) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                if (!busy) busy_ok = 1'b0;
                lat = e;
                break;
            end
            if (bcd !== prev) stable_ok = 1'b0;
        end
    endtask

    task automatic conv_check(input string tag, input logic [19:0] v, input logic n);
        int lat;
        logic bok, sok;
        do_conv(v, n, lat, bok, sok);
        check({tag, "_latency"}, 32'(lat), 32'd21);
        check({tag, "_busy"}, 32'(bok), 32'd1);
        check({tag, "_stable"}, 32'(sok), 32'd1);
        check_result(tag, 32'(v), n);
    endtask

    initial begin
        int unsigned q[$];
        int unsigned v;
        int dones;
        int done_edge;
        logic [19:0] pv;

        rstn = 1'b0;
        start = 1'b0;
        data_bny = '0;
        neg = 1'b0;
        #23;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bcd", 32'(bcd), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_neg", 32'(neg_out), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        conv_check("c123456", 20'd123456, 1'b0);
        conv_check("c999999", 20'd999999, 1'b0);
        conv_check("c1000000", 20'd1000000, 1'b0);
        conv_check("cFFFFF", 20'hFFFFF, 1'b1);
        conv_check("cneg0", 20'd0, 1'b1);
        conv_check("cneg7", 20'd7, 1'b1);
        conv_check("c4005", 20'd4005, 1'b0);
        conv_check("c100000", 20'd100000, 1'b0);
        conv_check("c0", 20'd0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            case (i % 3)
                0:       v = $urandom_range(0, 999);
                1:       v = $urandom_range(0, 999999);
                default: v = $urandom_range(0, 20'hFFFFF);
            endcase
            conv_check("crand", 20'(v), 1'($urandom));
        end

        // Reset in mid-shift: outputs clear at once and no done ever appears.
        @(negedge clk);
        data_bny = 20'd654321;
        neg = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_bcd", 32'(bcd), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrst_nodone", 32'(dones), 32'd0);
        conv_check("after_rst", 20'd98765, 1'b1);

        // Start pulses while busy are ignored.
        @(negedge clk);
        pv = 20'd314159;
        data_bny = pv;
        neg = 1'b0;
        start = 1'b1;
        @(posedge clk);
        dones = 0;
        done_edge = -1;
        for (int e = 1; e <= 45; e++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                done_edge = e - 1;
            end
            start = (e == 5 || e == 21);
            data_bny = 20'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        if (done) dones++;
        check("ign_dones", 32'(dones), 32'd1);
        check("ign_edge", 32'(done_edge), 32'd21);
        check_result("ign", 32'(pv), 1'b0);

        // Start held high: accepts every 22 edges with whatever data is present then.
        dones = 0;
        start = 1'b1;
        for (int e = 0; e < 66; e++) begin
            data_bny = 20'($urandom);
            neg = 1'b0;
            if (e % 22 == 0) q.push_back(32'(data_bny));
            @(posedge clk);
            @(negedge clk);
            if (e == 65) start = 1'b0;
            if (done) begin
                dones++;
                check("held_phase", 32'(e % 22), 32'd21);
                if (q.size() > 0) check_result("held", q.pop_front(), 1'b0);
            end
        end
        start = 1'b0;
        check("held_dones", 32'(dones), 32'd3);
        repeat (3) @(negedge clk);
        check("held_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
